// File: rtl/bsg_dram_read_tracker_pkg.sv
// Shared defaults and the end-of-test statistics bundle for the DRAM read tracker.
package bsg_dram_read_tracker_pkg;

  localparam int CH_ADDR_W_DEF = 29;
  localparam int NUM_REQ_DEF   = 64;
  localparam int CNT_W_DEF     = 32;
  localparam int LAT_W_DEF     = 16;
  localparam int LAT_SUM_W_DEF = 48;

  // Snapshot of the statistics outputs at the default widths.
  typedef struct packed {
    logic [CNT_W_DEF-1:0]     issued;
    logic [CNT_W_DEF-1:0]     completed;
    logic [LAT_SUM_W_DEF-1:0] lat_sum;
    logic [LAT_W_DEF-1:0]     lat_max;
  } stats_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with registered pointers; storage is not reset.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 16,
  parameter int els_p   = 64
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w = $clog2(els_p);

  // One extra pointer bit distinguishes full from empty.
  logic [ptr_w:0]       wptr_r, rptr_r;
  logic [width_p-1:0]   mem_r [els_p];
  logic                 full, empty, push, pop;

  assign empty   = (wptr_r == rptr_r);
  assign full    = (wptr_r[ptr_w] != rptr_r[ptr_w]) &&
                   (wptr_r[ptr_w-1:0] == rptr_r[ptr_w-1:0]);
  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign data_o  = mem_r[rptr_r[ptr_w-1:0]];
  assign push    = v_i & ~full;
  assign pop     = yumi_i & ~empty;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push) wptr_r <= wptr_r + (ptr_w+1)'(1);
      if (pop)  rptr_r <= rptr_r + (ptr_w+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_r[wptr_r[ptr_w-1:0]] <= data_i;
  end

endmodule

// File: rtl/bsg_dram_read_tracker.sv
// Credit-limited read issue toward one DRAM channel, with in-order latency
// timestamping and running issue/completion/latency statistics.
module bsg_dram_read_tracker
  import bsg_dram_read_tracker_pkg::*;
#(
  parameter int channel_addr_width_p = CH_ADDR_W_DEF,
  parameter int num_request_p        = NUM_REQ_DEF,
  parameter int counter_width_p      = CNT_W_DEF,
  parameter int lat_width_p          = LAT_W_DEF,
  parameter int lat_sum_width_p      = LAT_SUM_W_DEF
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 v_i,
  input  logic [channel_addr_width_p-1:0]      ch_addr_i,
  output logic                                 yumi_o,
  output logic                                 dram_v_o,
  output logic [channel_addr_width_p-1:0]      dram_ch_addr_o,
  input  logic                                 dram_yumi_i,
  input  logic                                 dram_data_v_i,
  output logic [$clog2(num_request_p+1)-1:0]   outstanding_o,
  output logic [counter_width_p-1:0]           issued_o,
  output logic [counter_width_p-1:0]           completed_o,
  output logic [lat_sum_width_p-1:0]           lat_sum_o,
  output logic [lat_width_p-1:0]               lat_max_o,
  output logic                                 idle_o,
  output logic                                 error_o
);

  localparam int out_w = $clog2(num_request_p+1);

  logic [out_w-1:0]           outstanding_r;
  logic [counter_width_p-1:0] issued_r, completed_r;
  logic [lat_sum_width_p-1:0] lat_sum_r;
  logic [lat_width_p-1:0]     lat_max_r, cycle_r, ts_head, latency;
  logic                       error_r, credit, ts_ready, ts_v, issue, resp;

  // The FIFO's ready is redundant with the credit count but keeps storage
  // overflow impossible even if the two ever drifted apart.
  assign credit         = outstanding_r < out_w'(num_request_p);
  assign dram_v_o       = reset_n_i & v_i & credit & ts_ready;
  assign dram_ch_addr_o = ch_addr_i;
  assign issue          = dram_yumi_i & dram_v_o;
  assign yumi_o         = issue;
  // A non-empty timestamp FIFO is exactly "something outstanding".
  assign resp           = dram_data_v_i & ts_v;
  assign latency        = cycle_r - ts_head;

  bsg_fifo_1r1w_small #(
    .width_p (lat_width_p),
    .els_p   (num_request_p)
  ) u_ts_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (issue),
    .ready_o   (ts_ready),
    .data_i    (cycle_r),
    .v_o       (ts_v),
    .data_o    (ts_head),
    .yumi_i    (resp)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cycle_r       <= '0;
      outstanding_r <= '0;
      issued_r      <= '0;
      completed_r   <= '0;
      lat_sum_r     <= '0;
      lat_max_r     <= '0;
      error_r       <= 1'b0;
    end else begin
      cycle_r <= cycle_r + lat_width_p'(1);
      if (issue) issued_r <= issued_r + counter_width_p'(1);
      if (issue && !resp)      outstanding_r <= outstanding_r + out_w'(1);
      else if (resp && !issue) outstanding_r <= outstanding_r - out_w'(1);
      if (resp) begin
        completed_r <= completed_r + counter_width_p'(1);
        lat_sum_r   <= lat_sum_r + lat_sum_width_p'(latency);
        if (latency > lat_max_r) lat_max_r <= latency;
      end
      if (dram_data_v_i && !ts_v) error_r <= 1'b1;
    end
  end

  assign outstanding_o = outstanding_r;
  assign issued_o      = issued_r;
  assign completed_o   = completed_r;
  assign lat_sum_o     = lat_sum_r;
  assign lat_max_o     = lat_max_r;
  assign idle_o        = (outstanding_r == '0) & ~v_i;
  assign error_o       = error_r;

endmodule

// File: tb/tb_bsg_dram_read_tracker.sv
// Randomised and directed bench for bsg_dram_read_tracker against a queue-based model.
module tb_bsg_dram_read_tracker;
  import bsg_dram_read_tracker_pkg::*;

  localparam int N  = 4;
  localparam int AW = 29;
  localparam int CW = 32;
  localparam int LW = 16;
  localparam int SW = 48;
  localparam int OW = $clog2(N+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          v_a, yumi_a, dv_a;
  logic [AW-1:0] addr_a;
  logic          yumi_o_a, dram_v_a, idle_a, err_a;
  logic [AW-1:0] dram_addr_a;
  logic [OW-1:0] out_a;
  logic [CW-1:0] iss_a, cmp_a;
  logic [SW-1:0] sum_a;
  logic [LW-1:0] max_a;

  logic          v_b, yumi_b, dv_b;
  logic [AW-1:0] addr_b;
  logic          yumi_o_b, dram_v_b, idle_b, err_b;
  logic [AW-1:0] dram_addr_b;
  logic [OW-1:0] out_b;
  logic [CW-1:0] iss_b, cmp_b;
  logic [SW-1:0] sum_b;
  logic [3:0]    max_b;

  bsg_dram_read_tracker #(
    .channel_addr_width_p(AW), .num_request_p(N), .counter_width_p(CW),
    .lat_width_p(LW), .lat_sum_width_p(SW)
  ) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_a), .ch_addr_i(addr_a),
    .yumi_o(yumi_o_a), .dram_v_o(dram_v_a), .dram_ch_addr_o(dram_addr_a),
    .dram_yumi_i(yumi_a), .dram_data_v_i(dv_a), .outstanding_o(out_a),
    .issued_o(iss_a), .completed_o(cmp_a), .lat_sum_o(sum_a),
    .lat_max_o(max_a), .idle_o(idle_a), .error_o(err_a)
  );

  bsg_dram_read_tracker #(
    .channel_addr_width_p(AW), .num_request_p(N), .counter_width_p(CW),
    .lat_width_p(4), .lat_sum_width_p(SW)
  ) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_b), .ch_addr_i(addr_b),
    .yumi_o(yumi_o_b), .dram_v_o(dram_v_b), .dram_ch_addr_o(dram_addr_b),
    .dram_yumi_i(yumi_b), .dram_data_v_i(dv_b), .outstanding_o(out_b),
    .issued_o(iss_b), .completed_o(cmp_b), .lat_sum_o(sum_b),
    .lat_max_o(max_b), .idle_o(idle_b), .error_o(err_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for instance A: in-order timestamp queue plus totals.
  logic [15:0]   mq[$];
  int unsigned   cyc;
  logic [CW-1:0] m_iss, m_cmp;
  logic [SW-1:0] m_sum;
  logic [LW-1:0] m_max;
  logic          m_err;
  logic          e_dram_v = 1'b0;
  logic          e_issue  = 1'b0;

  function automatic logic [15:0] lat_of(input logic [15:0] ts, input int unsigned c);
    return 16'(c) - ts;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      cyc   <= 0;
      m_iss <= '0;
      m_cmp <= '0;
      m_sum <= '0;
      m_max <= '0;
      m_err <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (dv_a && mq.size() > 0) begin
        m_cmp <= m_cmp + 1;
        m_sum <= m_sum + SW'(lat_of(mq[0], cyc));
        if (lat_of(mq[0], cyc) > m_max) m_max <= lat_of(mq[0], cyc);
        void'(mq.pop_front());
      end else if (dv_a) begin
        m_err <= 1'b1;
      end
      if (e_issue) begin
        mq.push_back(16'(cyc));
        m_iss <= m_iss + 1;
      end
    end
  end

  // Per-cycle comparison, late in the low phase once inputs have settled.
  always @(negedge clk) begin
    #2;
    e_dram_v = rst_n && v_a && (mq.size() < N);
    e_issue  = e_dram_v && yumi_a;
    chk("dram_v",      64'(dram_v_a), 64'(e_dram_v));
    chk("yumi",        64'(yumi_o_a), 64'(e_issue));
    chk("dram_addr",   64'(dram_addr_a), 64'(addr_a));
    chk("outstanding", 64'(out_a), 64'(mq.size()));
    chk("issued",      64'(iss_a), 64'(m_iss));
    chk("completed",   64'(cmp_a), 64'(m_cmp));
    chk("lat_sum",     64'(sum_a), 64'(m_sum));
    chk("lat_max",     64'(max_a), 64'(m_max));
    chk("idle",        64'(idle_a), 64'(mq.size() == 0 && !v_a));
    chk("error",       64'(err_a), 64'(m_err));
    chk("fifo_ready",  64'(dut_a.u_ts_fifo.ready_o), 64'(mq.size() < N));
  end

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  int unsigned sq[$];
  int unsigned due_q[$];
  int unsigned iss_q[$];
  longint      exp_sum;
  int          exp_cmp;
  int          pulses;
  int          issued_n;
  int          budget;
  int unsigned last_due, d, l;
  stats_s      sb, act_st;

  initial begin
    rst_n = 1'b0;
    v_a = 1'b1; yumi_a = 1'b0; dv_a = 1'b0; addr_a = '0;
    v_b = 1'b0; yumi_b = 1'b0; dv_b = 1'b0; addr_b = '0;

    // Held in reset with a pending request: nothing may go out.
    repeat (3) @(negedge clk);
    #3;
    chk("rst_dram_v", 64'(dram_v_a), 64'd0);
    chk("rst_yumi",   64'(yumi_o_a), 64'd0);
    chk("rst_issued", 64'(iss_a), 64'd0);
    chk("rst_error",  64'(err_a), 64'd0);
    @(negedge clk);
    v_a = 1'b0;
    rst_n = 1'b1;

    // Single read on A (issue 10, respond 30) and a wrapped read on B (14 -> 3).
    while (cyc < 40) begin
      @(negedge clk);
      v_a = 1'b0; yumi_a = 1'b0; dv_a = 1'b0;
      v_b = 1'b0; yumi_b = 1'b0; dv_b = 1'b0;
      if (cyc == 10) begin v_a = 1'b1; yumi_a = 1'b1; addr_a = AW'($urandom); end
      if (cyc == 30) dv_a = 1'b1;
      if (cyc == 14) begin v_b = 1'b1; yumi_b = 1'b1; addr_b = AW'($urandom); end
      if (cyc == 19) dv_b = 1'b1;
    end
    @(negedge clk);
    #3;
    chk("single_issued",    64'(iss_a), 64'd1);
    chk("single_completed", 64'(cmp_a), 64'd1);
    chk("single_lat_sum",   64'(sum_a), 64'd20);
    chk("single_lat_max",   64'(max_a), 64'd20);
    chk("single_outst",     64'(out_a), 64'd0);
    chk("single_idle",      64'(idle_a), 64'd1);
    chk("wrap_lat_sum",     64'(sum_b), 64'd5);
    chk("wrap_lat_max",     64'(max_b), 64'd5);
    chk("wrap_completed",   64'(cmp_b), 64'd1);

    // Saturation: DRAM accepts whenever offered.
    exp_sum = 20; exp_cmp = 1; pulses = 0;
    repeat (8) begin
      @(negedge clk);
      v_a = 1'b1; addr_a = AW'($urandom);
      yumi_a = (mq.size() < N);
      if (yumi_a) sq.push_back(cyc);
      #3;
      if (yumi_o_a) pulses++;
    end
    chk("sat_pulses", 64'(pulses), 64'd4);
    @(negedge clk);
    yumi_a = 1'b0;
    #3;
    chk("sat_dram_v", 64'(dram_v_a), 64'd0);
    chk("sat_outst",  64'(out_a), 64'd4);
    @(negedge clk);
    dv_a = 1'b1;
    exp_sum += cyc - sq.pop_front(); exp_cmp++;
    #3;
    chk("full_same_cycle", 64'(dram_v_a), 64'd0);
    @(negedge clk);
    dv_a = 1'b0;
    #3;
    chk("credit_next_cycle", 64'(dram_v_a), 64'd1);
    chk("credit_outst",      64'(out_a), 64'd3);
    @(negedge clk);
    yumi_a = 1'b1; sq.push_back(cyc);
    @(negedge clk);
    yumi_a = 1'b0; v_a = 1'b0; dv_a = 1'b1;
    exp_sum += cyc - sq.pop_front(); exp_cmp++;
    @(negedge clk);
    exp_sum += cyc - sq.pop_front(); exp_cmp++;
    // Issue and response together with two in flight.
    @(negedge clk);
    v_a = 1'b1; yumi_a = 1'b1; dv_a = 1'b1;
    exp_sum += cyc - sq.pop_front(); exp_cmp++;
    sq.push_back(cyc);
    @(negedge clk);
    v_a = 1'b0; yumi_a = 1'b0; dv_a = 1'b0;
    #3;
    chk("simul_outst",     64'(out_a), 64'd2);
    chk("simul_lat_sum",   64'(sum_a), 64'(exp_sum));
    chk("simul_completed", 64'(cmp_a), 64'(exp_cmp));
    @(negedge clk); dv_a = 1'b1;
    @(negedge clk); dv_a = 1'b1;
    @(negedge clk); dv_a = 1'b0;
    #3;
    chk("drain_outst", 64'(out_a), 64'd0);

    // Random stream of 1000 reads with 1..100-cycle response delay.
    pulse_reset();
    issued_n = 0; budget = 0; last_due = 0;
    sb = '0;
    while ((issued_n < 1000 || due_q.size() > 0) && budget < 60000) begin
      @(negedge clk);
      budget++;
      v_a    = (issued_n < 1000) && ($urandom_range(0, 9) < 8);
      addr_a = AW'($urandom);
      yumi_a = v_a && (mq.size() < N) && ($urandom_range(0, 9) < 7);
      dv_a   = (due_q.size() > 0) && (due_q[0] <= cyc);
      if (dv_a) begin
        void'(due_q.pop_front());
        l = cyc - iss_q.pop_front();
        sb.lat_sum = sb.lat_sum + SW'(l);
        if (LW'(l) > sb.lat_max) sb.lat_max = LW'(l);
        sb.completed = sb.completed + 1;
      end
      if (yumi_a) begin
        issued_n++;
        sb.issued = sb.issued + 1;
        iss_q.push_back(cyc);
        d = cyc + $urandom_range(1, 100);
        if (d <= last_due) d = last_due + 1;
        due_q.push_back(d);
        last_due = d;
      end
    end
    if (budget >= 60000) begin
      total++; bad++;
      $display("FAIL random_timeout issued=%0d pending=%0d", issued_n, due_q.size());
    end
    @(negedge clk);
    v_a = 1'b0; yumi_a = 1'b0; dv_a = 1'b0;
    #3;
    act_st = '{issued: iss_a, completed: cmp_a, lat_sum: sum_a, lat_max: max_a};
    chk("rand_issued",    64'(act_st.issued), 64'd1000);
    chk("rand_completed", 64'(act_st.completed), 64'd1000);
    chk("rand_lat_sum",   64'(act_st.lat_sum), 64'(sb.lat_sum));
    chk("rand_lat_max",   64'(act_st.lat_max), 64'(sb.lat_max));
    chk("rand_error",     64'(err_a), 64'd0);

    // Spurious response, then an asynchronous mid-cycle reset.
    @(negedge clk); dv_a = 1'b1;
    @(negedge clk); dv_a = 1'b0;
    #3;
    chk("spur_error",     64'(err_a), 64'd1);
    chk("spur_completed", 64'(cmp_a), 64'd1000);
    repeat (3) @(negedge clk);
    #3;
    chk("spur_sticky", 64'(err_a), 64'd1);
    @(negedge clk); v_a = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_error",     64'(err_a), 64'd0);
    chk("async_issued",    64'(iss_a), 64'd0);
    chk("async_completed", 64'(cmp_a), 64'd0);
    chk("async_lat_sum",   64'(sum_a), 64'd0);
    chk("async_lat_max",   64'(max_a), 64'd0);
    chk("async_dram_v",    64'(dram_v_a), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk); v_a = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
